// File: rtl/aipp_pkg.sv
// Shared types and constants for the VRM lead-time scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package aipp_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int LEAD_MIN  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_LEAD,
    ST_REL,
    ST_COOL
  } state_e;

endpackage

// File: rtl/aipp_rr_arbiter.sv
// Combinational round-robin pick over the pending vector.
// The search starts at ptr and wraps; the caller owns the pointer.
module aipp_rr_arbiter
  import aipp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  int unsigned j;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/aipp_lead_time_scheduler.sv
// Shares one VRM pre-charge trigger between N_REQ requesters:
// trigger, lead delay, release handshake, then cooldown.
module aipp_lead_time_scheduler
  import aipp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic [CNT_W-1:0] lead_ns,
  input  logic [CNT_W-1:0] cooldown_ns,
  output logic             vrm_trigger,
  output logic             rel_valid,
  output logic [IDX_W-1:0] rel_port,
  input  logic             rel_ready,
  output logic [N_REQ-1:0] pending,
  output logic             busy,
  output logic             coalesce
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] port_q, port_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cool_q, cool_d;
  logic             trig_q, trig_d;
  logic             relv_q, relv_d;
  logic             busy_q, busy_d;
  logic             coal_q, coal_d;

  logic             gnt_v;
  logic [IDX_W-1:0] gnt_idx;
  logic             grant;
  logic [N_REQ-1:0] clr;
  logic [CNT_W-1:0] cnt_dec;

  aipp_rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_arb (
    .req        (pend_q),
    .ptr        (ptr_q),
    .grant_valid(gnt_v),
    .grant_idx  (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    cnt_d   = cnt_q;
    cool_d  = cool_q;
    clr     = '0;
    grant   = (state_q == ST_IDLE) && enable && gnt_v;
    cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    if (grant) clr[gnt_idx] = 1'b1;
    // a new request in the grant cycle re-arms the bit
    pend_d = (pend_q & ~clr) | req;
    coal_d = |(req & pend_q & ~clr);
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_TRIG;
          port_d  = gnt_idx;
          ptr_d   = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
          cnt_d   = (lead_ns < CNT_W'(LEAD_MIN)) ? CNT_W'(LEAD_MIN) : lead_ns;
          cool_d  = cooldown_ns;
        end
      end
      ST_TRIG: begin
        cnt_d   = cnt_dec;
        state_d = (cnt_q > CNT_W'(1)) ? ST_LEAD : ST_REL;
      end
      ST_LEAD: begin
        cnt_d = cnt_dec;
        if (cnt_q <= CNT_W'(1)) state_d = ST_REL;
      end
      ST_REL: begin
        if (relv_q && rel_ready) begin
          cnt_d   = cool_q;
          state_d = (cool_q != '0) ? ST_COOL : ST_IDLE;
        end
      end
      ST_COOL: begin
        cnt_d = cnt_dec;
        if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    trig_d = (state_d == ST_TRIG);
    relv_d = (state_d == ST_REL);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      port_q  <= '0;
      cnt_q   <= '0;
      cool_q  <= '0;
      trig_q  <= 1'b0;
      relv_q  <= 1'b0;
      busy_q  <= 1'b0;
      coal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      cnt_q   <= cnt_d;
      cool_q  <= cool_d;
      trig_q  <= trig_d;
      relv_q  <= relv_d;
      busy_q  <= busy_d;
      coal_q  <= coal_d;
    end
  end

  assign vrm_trigger = trig_q;
  assign rel_valid   = relv_q;
  assign rel_port    = port_q;
  assign pending     = pend_q;
  assign busy        = busy_q;
  assign coalesce    = coal_q;

endmodule

// File: tb/tb_aipp_lead_time_scheduler.sv
// Scoreboard bench: stimulus queues expected trigger/release events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_aipp_lead_time_scheduler;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [N-1:0]  req = '0;
  logic [CW-1:0] lead_ns = 32'd1;
  logic [CW-1:0] cooldown_ns = '0;
  logic          vrm_trigger;
  logic          rel_valid;
  logic [IW-1:0] rel_port;
  logic          rel_ready = 1'b1;
  logic [N-1:0]  pending;
  logic          busy;
  logic          coalesce;

  aipp_lead_time_scheduler #(
    .N_REQ(N),
    .CNT_W(CW),
    .IDX_W(IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req        (req),
    .lead_ns    (lead_ns),
    .cooldown_ns(cooldown_ns),
    .vrm_trigger(vrm_trigger),
    .rel_valid  (rel_valid),
    .rel_port   (rel_port),
    .rel_ready  (rel_ready),
    .pending    (pending),
    .busy       (busy),
    .coalesce   (coalesce)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_rel;
    int port;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  n_coal = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit r, input int p, input int c);
    ev_t e;
    e.is_rel = r;
    e.port   = p;
    e.cyc    = c;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input bit r, input int p);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_%s: port %0d at cyc %0d, expected none",
               r ? "release" : "trigger", p, cyc);
    end else begin
      e = q.pop_front();
      chk(r ? "rel_kind" : "trig_kind", 64'(r), 64'(e.is_rel));
      chk(r ? "rel_port" : "trig_port", 64'(p), 64'(e.port));
      chk(r ? "rel_cycle" : "trig_cycle", 64'(cyc), 64'(e.cyc));
    end
  endtask

  logic          prv_v = 1'b0;
  logic [IW-1:0] prv_port = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (coalesce) n_coal++;
      if (vrm_trigger) pop_cmp(1'b0, int'(rel_port));
      if (rel_valid && prv_v) chk("rel_port_stable", 64'(rel_port), 64'(prv_port));
      if (rel_valid && rel_ready) pop_cmp(1'b1, int'(rel_port));
      prv_v    = rel_valid;
      prv_port = rel_port;
    end else begin
      prv_v = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int m);
    while (cyc < m) tick();
  endtask

  task automatic do_reset;
    rst_n       = 1'b0;
    req         = '0;
    enable      = 1'b1;
    rel_ready   = 1'b1;
    lead_ns     = 32'd1;
    cooldown_ns = '0;
    q.delete();
    tick();
    chk("reset_outputs",
        64'({vrm_trigger, rel_valid, rel_port, pending, busy, coalesce}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && (q.size() != 0 || busy); i++) tick();
    chk("drain_in_budget", 64'(q.size() == 0 && !busy), 64'd1);
  endtask

  int n;
  int m;

  initial begin
    tick();

    // long lead, single requester
    do_reset();
    lead_ns = 32'd14000;
    n = cyc;
    req = 4'b0001;
    push(1'b0, 0, n + 2);
    push(1'b1, 0, n + 2 + 14000);
    tick();
    req = '0;
    wait_done(20000);
    go(cyc + 5);

    // all four at once: rr order and 8-cycle trigger spacing
    do_reset();
    lead_ns     = 32'd1;
    cooldown_ns = 32'd5;
    n = cyc;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      push(1'b0, k, n + 2 + 8 * k);
      push(1'b1, k, n + 3 + 8 * k);
    end
    tick();
    req = '0;
    wait_done(200);
    chk("pending_drained", 64'(pending), 64'd0);

    // lead 0 acts as 1; release back-pressured for 10 cycles
    do_reset();
    lead_ns     = '0;
    cooldown_ns = '0;
    rel_ready   = 1'b0;
    n = cyc;
    req = 4'b0100;
    push(1'b0, 2, n + 2);
    push(1'b1, 2, n + 13);
    push(1'b0, 0, n + 15);
    push(1'b1, 0, n + 16);
    tick();
    req = '0;
    go(n + 3);
    chk("lead0_rel_rise", 64'(rel_valid), 64'd1);
    chk("lead0_port", 64'(rel_port), 64'd2);
    go(n + 4);
    req = 4'b0001;
    tick();
    req = '0;
    go(n + 12);
    chk("held_rel_valid", 64'(rel_valid), 64'd1);
    chk("held_pending", 64'(pending), 64'b0001);
    go(n + 13);
    rel_ready = 1'b1;
    wait_done(100);

    // coalescing repeat requests from port 2 while port 1 is served
    do_reset();
    lead_ns     = 32'd3;
    cooldown_ns = 32'd2;
    n = cyc;
    req = 4'b0010;
    push(1'b0, 1, n + 2);
    push(1'b1, 1, n + 5);
    push(1'b0, 2, n + 9);
    push(1'b1, 2, n + 12);
    tick();
    req = '0;
    n_coal = 0;
    go(n + 3);
    req = 4'b0100;
    tick();
    req = '0;
    chk("pending_set", 64'(pending), 64'b0100);
    go(n + 5);
    req = 4'b0100;
    tick();
    req = '0;
    go(n + 7);
    req = 4'b0100;
    tick();
    req = '0;
    wait_done(100);
    go(cyc + 10);
    chk("coalesce_pulses", 64'(n_coal), 64'd2);

    // enable gating with requests parked
    do_reset();
    enable  = 1'b0;
    lead_ns = 32'd1;
    n = cyc;
    req = 4'b0110;
    tick();
    req = '0;
    go(n + 6);
    chk("disabled_busy", 64'(busy), 64'd0);
    chk("disabled_pending", 64'(pending), 64'b0110);
    m = cyc;
    enable = 1'b1;
    push(1'b0, 1, m + 1);
    push(1'b1, 1, m + 2);
    push(1'b0, 2, m + 4);
    push(1'b1, 2, m + 5);
    wait_done(100);

    // asynchronous reset during the lead phase
    do_reset();
    lead_ns = 32'd100;
    n = cyc;
    req = 4'b1000;
    push(1'b0, 3, n + 2);
    tick();
    req = '0;
    go(n + 10);
    chk("busy_in_lead", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        64'({vrm_trigger, rel_valid, rel_port, pending, busy, coalesce}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    go(cyc + 150);
    chk("no_stale_events", 64'(q.size()), 64'd0);
    chk("idle_after_reset", 64'({busy, pending}), 64'd0);
    lead_ns = 32'd1;
    n = cyc;
    req = 4'b0001;
    push(1'b0, 0, n + 2);
    push(1'b1, 0, n + 3);
    tick();
    req = '0;
    wait_done(100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
